// File: rtl/ad7606_pkg.sv
// ad7606_pkg: shared definitions for the AD7606 sample sequencer
//   FSM state encoding, default pin timing, frame-period floor, channel clamp.
package ad7606_pkg;

    localparam logic [2:0] ST_ADRST  = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_CONVST = 3'd2;
    localparam logic [2:0] ST_WBH    = 3'd3;
    localparam logic [2:0] ST_WBL    = 3'd4;
    localparam logic [2:0] ST_RDL    = 3'd5;
    localparam logic [2:0] ST_RDH    = 3'd6;

    localparam int RST_CYC_DEF     = 4;
    localparam int CONVST_CYC_DEF  = 2;
    localparam int RD_LOW_CYC_DEF  = 3;
    localparam int RD_HIGH_CYC_DEF = 2;
    localparam int BUSY_TO_DEF     = 4096;
    localparam int MIN_PERIOD      = 64;

    // 1..8 pass through; 0 and anything above 8 mean a full 8-channel frame
    function automatic logic [3:0] clamp_nch(input logic [7:0] n);
        return (n == 8'd0 || n > 8'd8) ? 4'd8 : n[3:0];
    endfunction

endpackage

// File: rtl/ad7606_rate_gen.sv
// ad7606_rate_gen: frame request generator for the AD7606 sequencer
//   i_clk, i_rst   clock, async active-high reset
//   enable         capture running; counter clears and holds while low
//   trigger        0 = free-run period tick, 1 = synced ext_trig rising edge
//   period         frame period in cycles, floored at MIN_PERIOD here
//   ext_trig       asynchronous external trigger
//   req            1-cycle frame request
module ad7606_rate_gen
    import ad7606_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        enable,
    input  logic        trigger,
    input  logic [23:0] period,
    input  logic        ext_trig,
    output logic        req
);

    logic [23:0] cnt;
    logic [23:0] per;
    logic [2:0]  trig_s;
    logic        tick;
    logic        trig_rise;

    assign per       = (period < 24'(MIN_PERIOD)) ? 24'(MIN_PERIOD) : period;
    // >= rather than == so a shrinking period cannot strand the counter past terminal count
    assign tick      = enable && (cnt >= per - 24'd1);
    assign trig_rise = trig_s[1] && !trig_s[2];
    // gating by the live enable drops a request that coincides with enable falling
    assign req       = enable && (trigger ? trig_rise : tick);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt    <= '0;
            trig_s <= '0;
        end else begin
            cnt    <= (!enable || tick) ? 24'd0 : cnt + 24'd1;
            trig_s <= {trig_s[1:0], ext_trig};
        end
    end

endmodule

// File: rtl/ad7606_sample_seq.sv
// ad7606_sample_seq: AD7606 parallel-mode conversion/readout sequencer
//   i_clk, i_rst                 clock, async active-high reset
//   i_cap_chnnel_num/enable/
//   i_cap_speed/trigger          capture configuration from the command decoder
//   i_ext_trig, i_ad_busy        asynchronous inputs, synced internally
//   i_ad_data                    AD7606 DB[15:0]
//   o_ad_convst/cs_n/rd_n/reset  AD7606 control pins
//   o_sample_data/chan/valid/last  sample stream, no backpressure
//   o_overrun, o_busy_err        1-cycle error pulses
module ad7606_sample_seq
    import ad7606_pkg::*;
#(
    parameter int RST_CYC     = RST_CYC_DEF,
    parameter int CONVST_CYC  = CONVST_CYC_DEF,
    parameter int RD_LOW_CYC  = RD_LOW_CYC_DEF,
    parameter int RD_HIGH_CYC = RD_HIGH_CYC_DEF,
    parameter int BUSY_TO     = BUSY_TO_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_cap_chnnel_num,
    input  logic        i_cap_enable,
    input  logic [23:0] i_cap_speed,
    input  logic        i_cap_trigger,
    input  logic        i_ext_trig,
    input  logic        i_ad_busy,
    input  logic [15:0] i_ad_data,
    output logic        o_ad_convst,
    output logic        o_ad_cs_n,
    output logic        o_ad_rd_n,
    output logic        o_ad_reset,
    output logic [15:0] o_sample_data,
    output logic [2:0]  o_sample_chan,
    output logic        o_sample_valid,
    output logic        o_sample_last,
    output logic        o_overrun,
    output logic        o_busy_err
);

    logic [2:0]  state;
    logic [12:0] cnt;
    logic [3:0]  nch;
    logic [2:0]  ch;
    logic [23:0] period;
    logic [1:0]  busy_s;
    logic        req;
    logic        last_ch;

    ad7606_rate_gen u_rate_gen (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .enable   (i_cap_enable),
        .trigger  (i_cap_trigger),
        .period   (period),
        .ext_trig (i_ext_trig),
        .req      (req)
    );

    assign last_ch   = {1'b0, ch} == nch - 4'd1;
    assign o_overrun = req && (state != ST_IDLE);

    // cnt is a shared width/timeout counter: cleared on every state entry, saturating
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= ST_ADRST;
            cnt            <= '0;
            nch            <= 4'd8;
            ch             <= '0;
            period         <= '0;
            busy_s         <= '0;
            o_ad_convst    <= 1'b1;
            o_ad_cs_n      <= 1'b1;
            o_ad_rd_n      <= 1'b1;
            o_ad_reset     <= 1'b1;
            o_sample_data  <= '0;
            o_sample_chan  <= '0;
            o_sample_valid <= 1'b0;
            o_sample_last  <= 1'b0;
            o_busy_err     <= 1'b0;
        end else begin
            busy_s         <= {busy_s[0], i_ad_busy};
            cnt            <= (&cnt) ? cnt : cnt + 13'd1;
            o_sample_valid <= 1'b0;
            o_busy_err     <= 1'b0;
            case (state)
                // the reset-release cycle itself is not counted, giving RST_CYC full cycles high
                ST_ADRST: if (cnt == 13'(RST_CYC)) begin
                    state      <= ST_IDLE;
                    o_ad_reset <= 1'b0;
                end
                ST_IDLE: begin
                    period <= i_cap_speed;
                    if (req) begin
                        state       <= ST_CONVST;
                        cnt         <= '0;
                        nch         <= clamp_nch(i_cap_chnnel_num);
                        o_ad_convst <= 1'b0;
                    end
                end
                ST_CONVST: if (cnt == 13'(CONVST_CYC - 1)) begin
                    state       <= ST_WBH;
                    cnt         <= '0;
                    o_ad_convst <= 1'b1;
                end
                ST_WBH: if (busy_s[1]) begin
                    state <= ST_WBL;
                    cnt   <= '0;
                end else if (cnt >= 13'(BUSY_TO - 1)) begin
                    state      <= ST_IDLE;
                    o_busy_err <= 1'b1;
                end
                ST_WBL: if (!busy_s[1]) begin
                    state     <= ST_RDL;
                    cnt       <= '0;
                    ch        <= '0;
                    o_ad_cs_n <= 1'b0;
                    o_ad_rd_n <= 1'b0;
                end else if (cnt >= 13'(BUSY_TO - 1)) begin
                    state      <= ST_IDLE;
                    o_busy_err <= 1'b1;
                end
                ST_RDL: if (cnt == 13'(RD_LOW_CYC - 1)) begin
                    state          <= ST_RDH;
                    cnt            <= '0;
                    o_ad_rd_n      <= 1'b1;
                    o_sample_data  <= i_ad_data;
                    o_sample_chan  <= ch;
                    o_sample_last  <= last_ch;
                    o_sample_valid <= 1'b1;
                end
                ST_RDH: if (cnt == 13'(RD_HIGH_CYC - 1)) begin
                    cnt <= '0;
                    if (last_ch) begin
                        state     <= ST_IDLE;
                        o_ad_cs_n <= 1'b1;
                    end else begin
                        state     <= ST_RDL;
                        ch        <= ch + 3'd1;
                        o_ad_rd_n <= 1'b0;
                    end
                end
                default: state <= ST_ADRST;
            endcase
        end
    end

endmodule

// File: tb/tb_ad7606_sample_seq.sv
// tb_ad7606_sample_seq: directed bench for ad7606_sample_seq with an AD7606 model
`timescale 1ns/1ps
module tb_ad7606_sample_seq;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [7:0]  chn = 8'd8;
    logic        en = 1'b0;
    logic [23:0] speed = 24'd1000;
    logic        trig = 1'b0;
    logic        ext = 1'b0;
    logic        busy = 1'b0;
    logic        bfm_stuck = 1'b0;
    logic [15:0] db;
    logic        convst, cs_n, rd_n, ad_reset, valid, last, ovr, berr;
    logic [15:0] sdata;
    logic [2:0]  schan;

    int checks = 0;
    int errors = 0;

    int cyc = 0, n_conv = 0, n_ovr = 0, n_berr = 0, n_smp = 0, last_rise = 0, last_berr = 0;
    int          fall_cyc [0:63];
    logic [15:0] s_data [0:511];
    logic [2:0]  s_chan [0:511];
    logic        s_last [0:511];
    logic        conv_q = 1'b1;
    logic        rd_q = 1'b1;
    logic [2:0]  bfm_ch = 3'd0;

    always #5 i_clk = ~i_clk;

    ad7606_sample_seq dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_cap_chnnel_num (chn),
        .i_cap_enable     (en),
        .i_cap_speed      (speed),
        .i_cap_trigger    (trig),
        .i_ext_trig       (ext),
        .i_ad_busy        (busy),
        .i_ad_data        (db),
        .o_ad_convst      (convst),
        .o_ad_cs_n        (cs_n),
        .o_ad_rd_n        (rd_n),
        .o_ad_reset       (ad_reset),
        .o_sample_data    (sdata),
        .o_sample_chan    (schan),
        .o_sample_valid   (valid),
        .o_sample_last    (last),
        .o_overrun        (ovr),
        .o_busy_err       (berr)
    );

    // ADC model: channel pointer advances on each RD rise while CS is low
    always @(posedge i_clk) begin
        rd_q   <= rd_n;
        bfm_ch <= cs_n ? 3'd0 : (rd_n && !rd_q) ? bfm_ch + 3'd1 : bfm_ch;
    end
    assign db = rd_n ? 16'h0000 : 16'hA000 + {13'd0, bfm_ch};

    // ADC model: BUSY rises 2 cycles after CONVST rise and holds 200 cycles
    always begin
        @(posedge convst);
        if (!i_rst && !bfm_stuck) begin
            repeat (2) @(negedge i_clk);
            busy = 1'b1;
            repeat (200) @(negedge i_clk);
            busy = 1'b0;
        end
    end

    // event recorder, sampled away from the active edge
    always @(negedge i_clk) begin
        cyc    <= cyc + 1;
        conv_q <= convst;
        if (conv_q && !convst) begin
            n_conv <= n_conv + 1;
            fall_cyc[n_conv[5:0]] <= cyc;
        end
        if (!conv_q && convst) last_rise <= cyc;
        if (ovr) n_ovr <= n_ovr + 1;
        if (berr) begin
            n_berr    <= n_berr + 1;
            last_berr <= cyc;
        end
        if (valid) begin
            s_data[n_smp[8:0]] <= sdata;
            s_chan[n_smp[8:0]] <= schan;
            s_last[n_smp[8:0]] <= last;
            n_smp <= n_smp + 1;
        end
    end

    task automatic test_reset();
        int n, c0;
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({convst, cs_n, rd_n, ad_reset} !== 4'b1111) begin
            errors++;
            $display("FAIL reset_pins: convst/cs_n/rd_n/ad_reset=%b, required 1111", {convst, cs_n, rd_n, ad_reset});
        end
        checks++;
        if ({valid, last, ovr, berr} !== 4'b0000 || sdata !== 16'h0 || schan !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid/last/ovr/berr=%b data=%h chan=%0d, required 0000 0000 0", {valid, last, ovr, berr}, sdata, schan);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        n = 0;
        repeat (10) begin
            @(negedge i_clk);
            if (ad_reset) n++;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL reset_width: ad_reset high %0d cycles, required 4", n);
        end
        c0 = n_conv;
        repeat (200) @(negedge i_clk);
        checks++;
        if (n_conv != c0) begin
            errors++;
            $display("FAIL disabled_no_convst: %0d convst pulses, required 0", n_conv - c0);
        end
        checks++;
        if ({convst, cs_n, rd_n, ad_reset} !== 4'b1110) begin
            errors++;
            $display("FAIL idle_pins: convst/cs_n/rd_n/ad_reset=%b, required 1110", {convst, cs_n, rd_n, ad_reset});
        end
    endtask

    task automatic test_free_run();
        int c0, s0, j;
        chn = 8'd8; speed = 24'd1000; trig = 1'b0;
        c0 = n_conv; s0 = n_smp;
        en = 1'b1;
        for (int k = 0; k < 4000 && n_smp < s0 + 24; k++) @(negedge i_clk);
        en = 1'b0;
        checks++;
        if (n_smp - s0 < 24) begin
            errors++;
            $display("FAIL free_run_count: %0d samples, required 24", n_smp - s0);
        end
        checks++;
        if (fall_cyc[6'(c0 + 1)] - fall_cyc[6'(c0)] != 1000) begin
            errors++;
            $display("FAIL free_run_period1: %0d cycles, required 1000", fall_cyc[6'(c0 + 1)] - fall_cyc[6'(c0)]);
        end
        checks++;
        if (fall_cyc[6'(c0 + 2)] - fall_cyc[6'(c0 + 1)] != 1000) begin
            errors++;
            $display("FAIL free_run_period2: %0d cycles, required 1000", fall_cyc[6'(c0 + 2)] - fall_cyc[6'(c0 + 1)]);
        end
        for (int i = 0; i < 24; i++) begin
            j = s0 + i;
            checks++;
            if (s_data[9'(j)] !== 16'hA000 + 16'(i % 8) || s_chan[9'(j)] !== 3'(i % 8) || s_last[9'(j)] !== (i % 8 == 7)) begin
                errors++;
                $display("FAIL free_run_sample%0d: data=%h chan=%0d last=%b, required data=%h chan=%0d last=%b",
                         i, s_data[9'(j)], s_chan[9'(j)], s_last[9'(j)], 16'hA000 + 16'(i % 8), i % 8, i % 8 == 7);
            end
        end
        repeat (600) @(negedge i_clk);
    endtask

    task automatic test_period_floor();
        int c0, s0, b0, o1, o3, j;
        chn = 8'd8; speed = 24'd10; trig = 1'b0;
        c0 = n_conv; s0 = n_smp; b0 = n_berr; o1 = -1; o3 = -1;
        en = 1'b1;
        for (int k = 0; k < 2000 && n_smp < s0 + 24; k++) begin
            @(negedge i_clk);
            if (n_conv == c0 + 1 && o1 < 0) o1 = n_ovr;
            if (n_conv == c0 + 3 && o3 < 0) o3 = n_ovr;
        end
        en = 1'b0;
        checks++;
        if (fall_cyc[6'(c0 + 1)] - fall_cyc[6'(c0)] != 256 || fall_cyc[6'(c0 + 2)] - fall_cyc[6'(c0 + 1)] != 256) begin
            errors++;
            $display("FAIL floor_frame_spacing: %0d and %0d cycles, required 256 and 256",
                     fall_cyc[6'(c0 + 1)] - fall_cyc[6'(c0)], fall_cyc[6'(c0 + 2)] - fall_cyc[6'(c0 + 1)]);
        end
        checks++;
        if (o1 < 0 || o3 < 0 || o3 - o1 != 6) begin
            errors++;
            $display("FAIL floor_overrun: %0d overruns over two frames, required 6", o3 - o1);
        end
        checks++;
        if (n_berr != b0) begin
            errors++;
            $display("FAIL floor_no_busy_err: %0d busy errors, required 0", n_berr - b0);
        end
        for (int i = 0; i < 24; i++) begin
            j = s0 + i;
            checks++;
            if (s_data[9'(j)] !== 16'hA000 + 16'(i % 8) || s_chan[9'(j)] !== 3'(i % 8) || s_last[9'(j)] !== (i % 8 == 7)) begin
                errors++;
                $display("FAIL floor_sample%0d: data=%h chan=%0d last=%b, required data=%h chan=%0d last=%b",
                         i, s_data[9'(j)], s_chan[9'(j)], s_last[9'(j)], 16'hA000 + 16'(i % 8), i % 8, i % 8 == 7);
            end
        end
        repeat (600) @(negedge i_clk);
    endtask

    task automatic test_ext_trig();
        int c0, s0, o0, j;
        chn = 8'd0; speed = 24'd10; trig = 1'b1;
        c0 = n_conv; s0 = n_smp; o0 = n_ovr;
        en = 1'b1;
        for (int p = 0; p < 3; p++) begin
            repeat (20) @(negedge i_clk);
            ext = 1'b1;
            repeat (5) @(negedge i_clk);
            ext = 1'b0;
            repeat (400) @(negedge i_clk);
        end
        en = 1'b0;
        checks++;
        if (n_conv - c0 != 3) begin
            errors++;
            $display("FAIL ext_trig_frames: %0d frames, required 3", n_conv - c0);
        end
        checks++;
        if (n_ovr != o0 || n_smp - s0 != 24) begin
            errors++;
            $display("FAIL ext_trig_counts: overruns=%0d samples=%0d, required 0 and 24", n_ovr - o0, n_smp - s0);
        end
        for (int i = 0; i < 24; i++) begin
            j = s0 + i;
            checks++;
            if (s_data[9'(j)] !== 16'hA000 + 16'(i % 8) || s_chan[9'(j)] !== 3'(i % 8) || s_last[9'(j)] !== (i % 8 == 7)) begin
                errors++;
                $display("FAIL ext_trig_sample%0d: data=%h chan=%0d last=%b, required data=%h chan=%0d last=%b",
                         i, s_data[9'(j)], s_chan[9'(j)], s_last[9'(j)], 16'hA000 + 16'(i % 8), i % 8, i % 8 == 7);
            end
        end
        trig = 1'b0;
        repeat (600) @(negedge i_clk);
    endtask

    task automatic test_busy_timeout();
        int s0, b0, j;
        chn = 8'd4; speed = 24'd5000; trig = 1'b0;
        s0 = n_smp; b0 = n_berr;
        bfm_stuck = 1'b1;
        en = 1'b1;
        for (int k = 0; k < 12000 && n_berr == b0; k++) @(negedge i_clk);
        repeat (2) @(negedge i_clk);
        checks++;
        if (n_berr - b0 != 1) begin
            errors++;
            $display("FAIL busy_err_count: %0d pulses, required 1", n_berr - b0);
        end
        checks++;
        if (last_berr - last_rise != 4096) begin
            errors++;
            $display("FAIL busy_err_delay: %0d cycles after convst rise, required 4096", last_berr - last_rise);
        end
        checks++;
        if ({convst, cs_n, rd_n} !== 3'b111 || n_smp != s0) begin
            errors++;
            $display("FAIL busy_err_idle: convst/cs_n/rd_n=%b samples=%0d, required 111 and 0", {convst, cs_n, rd_n}, n_smp - s0);
        end
        bfm_stuck = 1'b0;
        for (int k = 0; k < 8000 && n_smp < s0 + 4; k++) @(negedge i_clk);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            j = s0 + i;
            checks++;
            if (n_smp < j + 1 || s_data[9'(j)] !== 16'hA000 + 16'(i) || s_chan[9'(j)] !== 3'(i) || s_last[9'(j)] !== (i == 3)) begin
                errors++;
                $display("FAIL recover_sample%0d: data=%h chan=%0d last=%b, required data=%h chan=%0d last=%b",
                         i, s_data[9'(j)], s_chan[9'(j)], s_last[9'(j)], 16'hA000 + 16'(i), i, i == 3);
            end
        end
        repeat (600) @(negedge i_clk);
    endtask

    task automatic test_enable_drop();
        int c0, s0, j, n;
        chn = 8'd4; speed = 24'd1000; trig = 1'b0;
        c0 = n_conv; s0 = n_smp;
        en = 1'b1;
        for (int k = 0; k < 3000 && n_smp < s0 + 3; k++) @(negedge i_clk);
        en = 1'b0;
        repeat (1500) @(negedge i_clk);
        checks++;
        if (n_smp - s0 != 4 || n_conv - c0 != 1) begin
            errors++;
            $display("FAIL drop_counts: samples=%0d frames=%0d, required 4 and 1", n_smp - s0, n_conv - c0);
        end
        for (int i = 0; i < 4; i++) begin
            j = s0 + i;
            checks++;
            if (s_data[9'(j)] !== 16'hA000 + 16'(i) || s_chan[9'(j)] !== 3'(i) || s_last[9'(j)] !== (i == 3)) begin
                errors++;
                $display("FAIL drop_sample%0d: data=%h chan=%0d last=%b, required data=%h chan=%0d last=%b",
                         i, s_data[9'(j)], s_chan[9'(j)], s_last[9'(j)], 16'hA000 + 16'(i), i, i == 3);
            end
        end
        en = 1'b1;
        for (int k = 0; k < 3000 && rd_n !== 1'b0; k++) @(negedge i_clk);
        checks++;
        if (rd_n !== 1'b0 || cs_n !== 1'b0) begin
            errors++;
            $display("FAIL reach_rdl: cs_n/rd_n=%b, required 00", {cs_n, rd_n});
        end
        i_rst = 1'b1;
        #1;
        checks++;
        if ({convst, cs_n, rd_n, ad_reset, valid} !== 5'b11110) begin
            errors++;
            $display("FAIL async_reset_pins: convst/cs_n/rd_n/ad_reset/valid=%b, required 11110", {convst, cs_n, rd_n, ad_reset, valid});
        end
        en = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        n = 0;
        repeat (10) begin
            @(negedge i_clk);
            if (ad_reset) n++;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL rerun_reset_width: ad_reset high %0d cycles, required 4", n);
        end
        c0 = n_conv;
        repeat (300) @(negedge i_clk);
        checks++;
        if (n_conv != c0 || {convst, cs_n, rd_n, ad_reset} !== 4'b1110) begin
            errors++;
            $display("FAIL post_reset_idle: frames=%0d pins=%b, required 0 and 1110", n_conv - c0, {convst, cs_n, rd_n, ad_reset});
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_period_floor();
        test_ext_trig();
        test_busy_timeout();
        test_enable_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
